// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head X/Y stepper with move-tick FSM and wall handling
// Optional SNAKE_WRAP_EN: wrap the head around the playfield edge instead of colliding.
module snake_head_stepper #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 10,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int TICK_DIV = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       pause,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [1:0] dir,
    output logic       step_pulse,
    output logic       collide
);

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    localparam int              CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]      STEP_POS  = 10'(STEP);
    localparam logic [9:0]      STEP_NEG  = 10'(1024 - STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    state_t        r_state;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [1:0]    r_dir;
    logic [1:0]    r_pend;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    logic          w_any_btn;
    logic [1:0]    w_req;
    logic [9:0]    w_operand;
    logic [9:0]    w_addend;
    logic [9:0]    w_sum;
    logic          w_carry;
    logic          w_hit;
    logic [9:0]    w_new;

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        w_req = DIR_R;
        if (btn_up)
            w_req = DIR_U;
        else if (btn_down)
            w_req = DIR_D;
        else if (btn_left)
            w_req = DIR_L;
    end

    // RIGHT and DOWN add +STEP; LEFT and UP add the two's complement of STEP.
    assign w_operand = r_pend[1] ? r_y : r_x;
    assign w_addend  = (r_pend[1] ~^ r_pend[0]) ? STEP_POS : STEP_NEG;

    always_comb begin
        w_sum   = '0;
        w_carry = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w_sum[i] = w_operand[i] ^ w_addend[i] ^ w_carry;
            w_carry  = (w_operand[i] & w_addend[i]) | (w_carry & (w_operand[i] ^ w_addend[i]));
        end
    end

    always_comb begin
        w_hit = 1'b0;
        case (r_pend)
            DIR_R:   w_hit = ({1'b0, r_x} + 11'(STEP)) > 11'(X_MAX);
            DIR_L:   w_hit = r_x < 10'(STEP);
            DIR_D:   w_hit = ({1'b0, r_y} + 11'(STEP)) > 11'(Y_MAX);
            default: w_hit = r_y < 10'(STEP);
        endcase
    end

`ifdef SNAKE_WRAP_EN
    always_comb begin
        w_new = w_sum;
        if (w_hit) begin
            case (r_pend)
                DIR_L:   w_new = 10'(X_MAX + 1 - STEP);
                DIR_U:   w_new = 10'(Y_MAX + 1 - STEP);
                default: w_new = 10'd0;
            endcase
        end
    end
    assign collide = 1'b0;
`else
    logic r_collide;
    assign w_new   = w_sum;
    assign collide = r_collide;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= 10'(START_X);
            r_y       <= 10'(START_Y);
            r_dir     <= DIR_R;
            r_pend    <= DIR_R;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
`ifndef SNAKE_WRAP_EN
            r_collide <= 1'b0;
`endif
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_btn) begin
                        r_pend  <= w_req;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Reverse test is against the applied direction, not the pending one.
                    if (w_any_btn && (w_req != (r_dir ^ 2'b01)))
                        r_pend <= w_req;
                    if (!pause) begin
                        if (r_cnt == TICK_LAST) begin
                            r_cnt   <= '0;
                            r_dir   <= r_pend;
                            r_pulse <= 1'b1;
`ifdef SNAKE_WRAP_EN
                            if (r_pend[1])
                                r_y <= w_new;
                            else
                                r_x <= w_new;
`else
                            if (w_hit) begin
                                r_collide <= 1'b1;
                                r_state   <= S_DEAD;
                            end else if (r_pend[1]) begin
                                r_y <= w_new;
                            end else begin
                                r_x <= w_new;
                            end
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DEAD: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_pos      = r_x;
    assign y_pos      = r_y;
    assign dir        = r_dir;
    assign step_pulse = r_pulse;

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - scoreboard bench for snake_head_stepper (TICK_DIV=4)
module tb_snake_head_stepper;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right, pause;
    logic [9:0] x_pos, y_pos;
    logic [1:0] dir;
    logic       step_pulse, collide;

    snake_head_stepper #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pause(pause),
        .x_pos(x_pos), .y_pos(y_pos), .dir(dir),
        .step_pulse(step_pulse), .collide(collide)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
        int col;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_pulse) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d got x=%0d y=%0d dir=%0d col=%0d, required no pulse",
                         cyc, x_pos, y_pos, dir, collide);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(x_pos) != e.x || int'(y_pos) != e.y || int'(dir) != e.d ||
                    int'(collide) != e.col || cyc != e.at) begin
                    n_err++;
                    $display("FAIL step got x=%0d y=%0d dir=%0d col=%0d cyc=%0d, required x=%0d y=%0d dir=%0d col=%0d cyc=%0d",
                             x_pos, y_pos, dir, collide, cyc, e.x, e.y, e.d, e.col, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int d, input int col, input int at);
        exp_t e;
        e.x = x; e.y = y; e.d = d; e.col = col; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"}, int'(x_pos), 320);
        check({tag, "_y"}, int'(y_pos), 240);
        check({tag, "_dir"}, int'(dir), 0);
        check({tag, "_collide"}, int'(collide), 0);
        check({tag, "_pulse"}, int'(step_pulse), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; pause = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        repeat (20) @(negedge clk);
        check("idle_x", int'(x_pos), 320);
        check("idle_y", int'(y_pos), 240);

        // Start RIGHT, then up+left together, then a reversed DOWN, then turn RIGHT to the wall.
        c = cyc;
        btn_right = 1;
        push(330, 240, 0, 0, c + 5);
        push(340, 240, 0, 0, c + 9);
        push(350, 240, 0, 0, c + 13);
        @(negedge clk);
        btn_right = 0;
        wait_until(c + 13);
        btn_left = 1; btn_up = 1;
        push(350, 230, 2, 0, c + 17);
        @(negedge clk);
        btn_left = 0; btn_up = 0;
        wait_until(c + 17);
        btn_down = 1;
        push(350, 220, 2, 0, c + 21);
        push(350, 210, 2, 0, c + 25);
        @(negedge clk);
        btn_down = 0;
        wait_until(c + 25);
        btn_right = 1;
        for (int k = 0; k <= 27; k++) push(360 + 10 * k, 210, 0, 0, c + 29 + 4 * k);
        push(WRAP ? 0 : 630, 210, 0, WRAP ? 0 : 1, c + 141);
        @(negedge clk);
        btn_right = 0;
        wait_until(c + 141);
        if (!WRAP) begin
            repeat (20) @(negedge clk);
            check("dead_x", int'(x_pos), 630);
            check("dead_collide", int'(collide), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_after_wall");

        // Pause mid-count, then reset on the cycle before a tick.
        c = cyc;
        btn_right = 1;
        push(330, 240, 0, 0, c + 5);
        push(340, 240, 0, 0, c + 9);
        push(350, 240, 0, 0, c + 23);
        @(negedge clk);
        btn_right = 0;
        wait_until(c + 10);
        pause = 1;
        wait_until(c + 15);
        check("pause_x", int'(x_pos), 340);
        wait_until(c + 20);
        pause = 0;
        wait_until(c + 26);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_before_tick");

        // Climb UP to the top wall.
        c = cyc;
        btn_up = 1;
        for (int k = 0; k <= 23; k++) push(320, 230 - 10 * k, 2, 0, c + 5 + 4 * k);
        push(320, WRAP ? 470 : 0, 2, WRAP ? 0 : 1, c + 101);
        @(negedge clk);
        btn_up = 0;
        wait_until(c + 101);
        if (!WRAP) begin
            repeat (12) @(negedge clk);
            check("top_collide", int'(collide), 1);
            check("top_y", int'(y_pos), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("final_rst");
        repeat (8) @(negedge clk);
        check("pending_steps", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
